// File: rtl/led_sequencer_if.sv
// led_sequencer_if: groups the requester strobes, LED drives and status of led_sequencer.
//   master: the requesting side (MMIO decode / button logic); drives cmd_* and echo_*,
//           observes LEDs and status.
//   slave : led_sequencer itself.
// Signals:
//   cmd_valid/cmd_color   CPU flash push strobe and colour (00 red, 01 blue, 10 green, 11 yellow)
//   echo_valid/echo_color button echo request strobe and colour
//   red/blue/green/yellow_led  registered LED drives, at most one high
//   busy, fifo_count, fifo_full, cmd_drop  status for MMIO readback
interface led_sequencer_if #(
    parameter int unsigned DEPTH = 8
);
    logic                     cmd_valid;
    logic [1:0]               cmd_color;
    logic                     echo_valid;
    logic [1:0]               echo_color;
    logic                     red_led;
    logic                     blue_led;
    logic                     green_led;
    logic                     yellow_led;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     fifo_full;
    logic                     cmd_drop;

    modport master (
        output cmd_valid, cmd_color, echo_valid, echo_color,
        input  red_led, blue_led, green_led, yellow_led,
        input  busy, fifo_count, fifo_full, cmd_drop
    );

    modport slave (
        input  cmd_valid, cmd_color, echo_valid, echo_color,
        output red_led, blue_led, green_led, yellow_led,
        output busy, fifo_count, fifo_full, cmd_drop
    );
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: schedules the four game LEDs between queued CPU flash commands and
// button echo requests. CPU commands sit in a DEPTH-entry FIFO and each plays as
// ON_CYCLES lit plus GAP_CYCLES dark; a single pending echo register plays ECHO_CYCLES
// lit plus GAP_CYCLES dark once the FIFO is empty.
// Ports:
//   clock  system clock
//   reset  asynchronous active-high; clears all state and drops the LEDs immediately
//   bus    led_sequencer_if.slave (requests in, LEDs and status out)
module led_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ON_CYCLES   = 25000000,
    parameter int unsigned GAP_CYCLES  = 5000000,
    parameter int unsigned ECHO_CYCLES = 10000000,
    parameter int unsigned CNT_W       = 25
) (
    input  logic            clock,
    input  logic            reset,
    led_sequencer_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SHOW, ECHO, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [1:0]       mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             echo_pending;
    logic [1:0]       echo_color_q;
    logic [3:0]       leds;          // {yellow, green, blue, red}
    logic             cmd_drop_q;

    logic             select;
    logic             pop;
    logic             echo_take;
    logic             push;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    // Select point: idle, or the final GAP cycle so back-to-back flashes have no idle gap.
    // A full FIFO still accepts a push on the edge that pops its head.
    always_comb begin
        select    = (state == IDLE) || ((state == GAP) && (timer == '0));
        pop       = select && (count != '0);
        echo_take = select && (count == '0) && echo_pending;
        push      = bus.cmd_valid && ((count != CW'(DEPTH)) || pop);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.cmd_color;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            echo_pending <= 1'b0;
            echo_color_q <= '0;
            leds         <= '0;
            cmd_drop_q   <= 1'b0;
        end else begin
            cmd_drop_q <= bus.cmd_valid && !push;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            // A new press always wins, even on the edge the old one is consumed.
            if (bus.echo_valid) begin
                echo_pending <= 1'b1;
                echo_color_q <= bus.echo_color;
            end else if (echo_take) begin
                echo_pending <= 1'b0;
            end

            case (state)
                IDLE, GAP: begin
                    if (select) begin
                        if (pop) begin
                            state <= SHOW;
                            timer <= CNT_W'(ON_CYCLES - 1);
                            leds  <= onehot(mem[rd_ptr]);
                        end else if (echo_take) begin
                            state <= ECHO;
                            timer <= CNT_W'(ECHO_CYCLES - 1);
                            leds  <= onehot(echo_color_q);
                        end else begin
                            state <= IDLE;
                            timer <= '0;
                            leds  <= '0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SHOW, ECHO: begin
                    if (timer == '0) begin
                        state <= GAP;
                        timer <= CNT_W'(GAP_CYCLES - 1);
                        leds  <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.red_led    = leds[0];
    assign bus.blue_led   = leds[1];
    assign bus.green_led  = leds[2];
    assign bus.yellow_led = leds[3];
    assign bus.busy       = (state != IDLE) || (count != '0);
    assign bus.fifo_count = count;
    assign bus.fifo_full  = (count == CW'(DEPTH));
    assign bus.cmd_drop   = cmd_drop_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: self-checking bench for led_sequencer (DEPTH=4, ON=4, GAP=2, ECHO=3).
// A monitor turns the LED pins into flash records {colour, lit cycles, dark cycles};
// tests push the flashes they expect and compare against recorded ones, plus
// cycle-exact checks of latency, FIFO status and reset behaviour.
`timescale 1ns/1ps
module tb_led_sequencer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ON    = 4;
    localparam int unsigned GAP   = 2;
    localparam int unsigned ECHO  = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    led_sequencer_if #(.DEPTH(DEPTH)) bus ();

    led_sequencer #(
        .DEPTH(DEPTH), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .ECHO_CYCLES(ECHO), .CNT_W(25)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] color;
        logic [7:0] lit;
        logic [7:0] dark;
    } flash_t;

    flash_t exp_q[$];
    flash_t obs_q[$];
    int checks    = 0;
    int failures  = 0;
    int multi_cnt = 0;

    function automatic logic [3:0] led_vec();
        return {bus.yellow_led, bus.green_led, bus.blue_led, bus.red_led};
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] r = '0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    function automatic flash_t mk(input logic [1:0] c, input int lit);
        return {c, 8'(lit), 8'(GAP)};
    endfunction

    // Flash recorder: lit run of one LED, then dark run while still busy.
    initial begin : monitor
        logic [3:0] v;
        logic [3:0] cur;
        int lit, dark, phase;
        cur = '0; lit = 0; dark = 0; phase = 0;
        forever begin
            @(negedge clock);
            v = led_vec();
            if ($countones(v) > 1) multi_cnt++;
            if (reset) begin
                phase = 0;
            end else begin
                case (phase)
                    0: if (v != 0) begin cur = v; lit = 1; phase = 1; end
                    1: begin
                        if (v == cur) lit++;
                        else if (v == 0) begin dark = 1; phase = 2; end
                        else begin
                            obs_q.push_back(flash_t'({enc(cur), 8'(lit), 8'd0}));
                            cur = v; lit = 1;
                        end
                    end
                    default: begin
                        if (v == 0 && bus.busy) dark++;
                        else begin
                            obs_q.push_back(flash_t'({enc(cur), 8'(lit), 8'(dark)}));
                            if (v != 0) begin cur = v; lit = 1; phase = 1; end
                            else phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_obs(input int n, output bit ok);
        int cyc = 0;
        while (obs_q.size() < n && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (led_vec() !== 4'b0000) begin failures++; $display("FAIL reset_leds: got %b, required 0000", led_vec()); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        checks++;
        if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d, required 0", bus.fifo_count); end
        checks++;
        if ({bus.fifo_full, bus.cmd_drop} !== 2'b00) begin
            failures++; $display("FAIL reset_flags: full/drop got %b, required 00", {bus.fifo_full, bus.cmd_drop});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        flash_t e, o;
        bit ok;
        bus.cmd_valid = 1'b1; bus.cmd_color = 2'd0;
        exp_q.push_back(mk(2'd0, ON));
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.fifo_count !== 3'd1 || bus.red_led !== 1'b0) begin
            failures++; $display("FAIL single_latency: count=%0d red=%b, required count=1 red=0", bus.fifo_count, bus.red_led);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            checks++;
            if (bus.red_led !== (k <= 4) || bus.busy !== (k <= 6)) begin
                failures++;
                $display("FAIL single_cycle%0d: red=%b busy=%b, required red=%b busy=%b", k, bus.red_led, bus.busy, (k <= 4), (k <= 6));
            end
        end
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout: flashes %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_flash: got c=%0d lit=%0d dark=%0d, required c=%0d lit=%0d dark=%0d", o.color, o.lit, o.dark, e.color, e.lit, e.dark);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [1:0] cols [3] = '{2'd1, 2'd2, 2'd3};
        flash_t e, o;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_color = cols[i];
            exp_q.push_back(mk(cols[i], ON));
            @(negedge clock);
        end
        bus.cmd_valid = 1'b0;
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_timeout: flashes %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_flash: got c=%0d lit=%0d dark=%0d, required c=%0d lit=%0d dark=%0d", o.color, o.lit, o.dark, e.color, e.lit, e.dark);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy: got %b, required 0", bus.busy); end
    endtask

    // Leaves the FIFO full, GAP timer at zero: the next edge pops.
    task automatic test_overflow();
        logic [1:0] cols [7]    = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [2:0] exp_cnt [7] = '{3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        for (int e = 0; e < 7; e++) begin
            bus.cmd_valid = (e != 1);
            bus.cmd_color = cols[e];
            if (e != 1 && e != 6) exp_q.push_back(mk(cols[e], ON));
            @(negedge clock);
            checks++;
            if (bus.fifo_count !== exp_cnt[e] || bus.cmd_drop !== (e == 6) || bus.fifo_full !== (e >= 5)) begin
                failures++;
                $display("FAIL overflow_edge%0d: count=%0d drop=%b full=%b, required count=%0d drop=%b full=%b",
                         e, bus.fifo_count, bus.cmd_drop, bus.fifo_full, exp_cnt[e], (e == 6), (e >= 5));
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_push_on_pop();
        flash_t e, o;
        bit ok;
        bus.cmd_valid = 1'b1; bus.cmd_color = 2'd3;
        exp_q.push_back(mk(2'd3, ON));
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.fifo_count !== 3'd4 || bus.cmd_drop !== 1'b0 || bus.fifo_full !== 1'b1) begin
            failures++;
            $display("FAIL pushpop_status: count=%0d drop=%b full=%b, required count=4 drop=0 full=1", bus.fifo_count, bus.cmd_drop, bus.fifo_full);
        end
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL pushpop_timeout: flashes %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pushpop_flash: got c=%0d lit=%0d dark=%0d, required c=%0d lit=%0d dark=%0d", o.color, o.lit, o.dark, e.color, e.lit, e.dark);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_echo_queue();
        flash_t e, o;
        bit ok;
        exp_q.push_back(mk(2'd3, ON));
        exp_q.push_back(mk(2'd1, ON));
        exp_q.push_back(mk(2'd0, ECHO));
        for (int k = 0; k < 10; k++) begin
            bus.cmd_valid  = (k < 2);
            bus.cmd_color  = (k == 0) ? 2'd3 : 2'd1;
            bus.echo_valid = (k == 3 || k == 9);
            bus.echo_color = (k == 3) ? 2'd2 : 2'd0;
            @(negedge clock);
        end
        bus.cmd_valid = 1'b0; bus.echo_valid = 1'b0;
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL echoq_timeout: flashes %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL echoq_flash: got c=%0d lit=%0d dark=%0d, required c=%0d lit=%0d dark=%0d", o.color, o.lit, o.dark, e.color, e.lit, e.dark);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_echo_rearm();
        flash_t e, o;
        bit ok;
        exp_q.push_back(mk(2'd1, ECHO));
        exp_q.push_back(mk(2'd3, ECHO));
        bus.echo_valid = 1'b1; bus.echo_color = 2'd1;
        @(negedge clock);
        bus.echo_color = 2'd3;
        @(negedge clock);
        bus.echo_valid = 1'b0;
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rearm_timeout: flashes %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rearm_flash: got c=%0d lit=%0d dark=%0d, required c=%0d lit=%0d dark=%0d", o.color, o.lit, o.dark, e.color, e.lit, e.dark);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_show();
        logic [1:0] cols [3] = '{2'd2, 2'd3, 2'd1};
        flash_t e, o;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_color = cols[i];
            @(negedge clock);
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.green_led !== 1'b1 || bus.fifo_count !== 3'd2) begin
            failures++; $display("FAIL midreset_pre: green=%b count=%0d, required green=1 count=2", bus.green_led, bus.fifo_count);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (led_vec() !== 4'b0000 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: leds=%b count=%0d busy=%b, required leds=0000 count=0 busy=0", led_vec(), bus.fifo_count, bus.busy);
        end
        @(negedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        bus.cmd_valid = 1'b1; bus.cmd_color = 2'd0;
        exp_q.push_back(mk(2'd0, ON));
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midreset_timeout: flashes %0d, required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midreset_flash: got c=%0d lit=%0d dark=%0d, required c=%0d lit=%0d dark=%0d", o.color, o.lit, o.dark, e.color, e.lit, e.dark);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_onehot();
        checks++;
        if (multi_cnt !== 0) begin failures++; $display("FAIL onehot: multi-LED samples %0d, required 0", multi_cnt); end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_color  = 2'd0;
        bus.echo_valid = 1'b0;
        bus.echo_color = 2'd0;
        repeat (2) @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_on_pop();
        test_echo_queue();
        test_echo_rearm();
        test_reset_mid_show();
        test_onehot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
